// File: rtl/id_issue_stage_pkg.sv
// Shared opcode/funct/ALU encodings and the instruction decoder for id_issue_stage.
// Reset constants are written for an active-low reset.
package id_issue_stage_pkg;

  localparam logic RstActive = 1'b0;

  localparam int unsigned AluOpW  = 8;
  localparam int unsigned AluSelW = 3;

  typedef enum logic [5:0] {
    OpSpecial = 6'b000000,
    OpAndi    = 6'b001100,
    OpOri     = 6'b001101,
    OpXori    = 6'b001110,
    OpLui     = 6'b001111
  } opcode_e;

  typedef enum logic [5:0] {
    FnAnd = 6'b100100,
    FnOr  = 6'b100101,
    FnXor = 6'b100110,
    FnNor = 6'b100111
  } funct_e;

  typedef enum logic [AluOpW-1:0] {
    AluNop = 8'h00,
    AluAnd = 8'h24,
    AluOr  = 8'h25,
    AluXor = 8'h26,
    AluNor = 8'h27
  } alu_op_e;

  typedef enum logic [AluSelW-1:0] {
    ResNop   = 3'b000,
    ResLogic = 3'b001
  } alu_sel_e;

  typedef struct packed {
    alu_op_e     aluop;
    alu_sel_e    alusel;
    logic        reg1_read;
    logic        reg2_read;
    logic        wreg;
    logic        wd_rd;     // destination is rd (R-type) rather than rt
    logic        illegal;
    logic [31:0] imm;
  } dec_t;

  localparam dec_t DecNop = '{
    aluop: AluNop, alusel: ResNop, reg1_read: 1'b0, reg2_read: 1'b0,
    wreg: 1'b0, wd_rd: 1'b0, illegal: 1'b1, imm: 32'h0
  };

  function automatic dec_t decode(input logic [31:0] inst);
    dec_t d;
    d = DecNop;
    case (inst[31:26])
      OpOri, OpAndi, OpXori: begin
        d.alusel    = ResLogic;
        d.reg1_read = 1'b1;
        d.wreg      = 1'b1;
        d.illegal   = 1'b0;
        d.imm       = {16'h0, inst[15:0]};
        case (inst[31:26])
          OpAndi:  d.aluop = AluAnd;
          OpXori:  d.aluop = AluXor;
          default: d.aluop = AluOr;
        endcase
      end
      OpLui: begin
        // Both operands carry the shifted immediate, so OR yields it unchanged.
        d.aluop   = AluOr;
        d.alusel  = ResLogic;
        d.wreg    = 1'b1;
        d.illegal = 1'b0;
        d.imm     = {inst[15:0], 16'h0};
      end
      OpSpecial: begin
        d.alusel    = ResLogic;
        d.reg1_read = 1'b1;
        d.reg2_read = 1'b1;
        d.wreg      = 1'b1;
        d.wd_rd     = 1'b1;
        d.illegal   = 1'b0;
        case (inst[5:0])
          FnAnd:   d.aluop = AluAnd;
          FnOr:    d.aluop = AluOr;
          FnXor:   d.aluop = AluXor;
          FnNor:   d.aluop = AluNor;
          default: d = DecNop;
        endcase
      end
      default: d = DecNop;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// Per-read-port operand select and RAW hazard detection against NUM_FWD in-flight writers.
// ID_BYPASS_EN selects forwarding; when undefined any matching writer interlocks.
module id_fwd_mux #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_FWD = 2
) (
  input  logic                      read_i,
  input  logic [REG_AW-1:0]         addr_i,
  input  logic [DATA_W-1:0]         imm_i,
  input  logic [DATA_W-1:0]         rdata_i,
  input  logic [NUM_FWD-1:0]        fwd_wreg_i,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_wd_i,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i,
  input  logic [NUM_FWD-1:0]        fwd_pend_i,
  output logic [DATA_W-1:0]         operand_o,
  output logic                      hazard_o
);

`ifndef ID_BYPASS_EN
  logic unused_fwd;
  assign unused_fwd = ^{fwd_wdata_i, fwd_pend_i};
`endif

  always_comb begin
    logic found;
    found     = 1'b0;
    operand_o = rdata_i;
    hazard_o  = 1'b0;
    for (int k = 0; k < int'(NUM_FWD); k++) begin
      if (!found && fwd_wreg_i[k] && (fwd_wd_i[k*REG_AW +: REG_AW] == addr_i)) begin
`ifdef ID_BYPASS_EN
        // Lowest index is the youngest writer and takes priority.
        found     = 1'b1;
        operand_o = fwd_wdata_i[k*DATA_W +: DATA_W];
        hazard_o  = fwd_pend_i[k];
`else
        found    = 1'b1;
        hazard_o = 1'b1;
`endif
      end
    end
    if (!read_i) begin
      operand_o = imm_i;
      hazard_o  = 1'b0;
    end else if (addr_i == '0) begin
      operand_o = '0;
      hazard_o  = 1'b0;
    end
  end

endmodule

// File: rtl/id_issue_stage.sv
// Decode stage: regfile read, operand forwarding / load-use interlock, registered ID/EX output
// with valid/ready handshake. Define ID_BYPASS_EN to enable forwarding (else full interlock).
module id_issue_stage
  import id_issue_stage_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [DATA_W-1:0]         pc_i,
  input  logic [31:0]               inst_i,
  output logic                      reg1_read_o,
  output logic                      reg2_read_o,
  output logic [REG_AW-1:0]         reg1_addr_o,
  output logic [REG_AW-1:0]         reg2_addr_o,
  input  logic [DATA_W-1:0]         reg1_data_i,
  input  logic [DATA_W-1:0]         reg2_data_i,
  input  logic [NUM_FWD-1:0]        fwd_wreg_i,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_wd_i,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i,
  input  logic [NUM_FWD-1:0]        fwd_pend_i,
  input  logic                      flush_i,
  output logic                      ex_valid_o,
  input  logic                      ex_ready_i,
  output logic [DATA_W-1:0]         ex_pc_o,
  output logic [AluOpW-1:0]         ex_aluop_o,
  output logic [AluSelW-1:0]        ex_alusel_o,
  output logic [DATA_W-1:0]         ex_reg1_o,
  output logic [DATA_W-1:0]         ex_reg2_o,
  output logic [REG_AW-1:0]         ex_wd_o,
  output logic                      ex_wreg_o,
  output logic                      ex_illegal_o,
  output logic [CNT_W-1:0]          stall_cnt_o
);

  dec_t              dec;
  logic [DATA_W-1:0] imm, op1, op2;
  logic              haz1, haz2, stall, capture;
  logic [REG_AW-1:0] wd;

  logic               ex_valid_q, ex_valid_d;
  logic [DATA_W-1:0]  pc_q, pc_d, reg1_q, reg1_d, reg2_q, reg2_d;
  logic [AluOpW-1:0]  aluop_q, aluop_d;
  logic [AluSelW-1:0] alusel_q, alusel_d;
  logic [REG_AW-1:0]  wd_q, wd_d;
  logic               wreg_q, wreg_d, ill_q, ill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  assign dec         = decode(inst_i);
  assign imm         = DATA_W'(dec.imm);
  assign reg1_read_o = dec.reg1_read;
  assign reg2_read_o = dec.reg2_read;
  assign reg1_addr_o = REG_AW'(inst_i[25:21]);
  assign reg2_addr_o = REG_AW'(inst_i[20:16]);
  assign wd          = !dec.wreg ? '0 :
                       dec.wd_rd ? REG_AW'(inst_i[15:11]) : REG_AW'(inst_i[20:16]);

  id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_fwd1 (
    .read_i      (reg1_read_o),
    .addr_i      (reg1_addr_o),
    .imm_i       (imm),
    .rdata_i     (reg1_data_i),
    .fwd_wreg_i  (fwd_wreg_i),
    .fwd_wd_i    (fwd_wd_i),
    .fwd_wdata_i (fwd_wdata_i),
    .fwd_pend_i  (fwd_pend_i),
    .operand_o   (op1),
    .hazard_o    (haz1)
  );

  id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_fwd2 (
    .read_i      (reg2_read_o),
    .addr_i      (reg2_addr_o),
    .imm_i       (imm),
    .rdata_i     (reg2_data_i),
    .fwd_wreg_i  (fwd_wreg_i),
    .fwd_wd_i    (fwd_wd_i),
    .fwd_wdata_i (fwd_wdata_i),
    .fwd_pend_i  (fwd_pend_i),
    .operand_o   (op2),
    .hazard_o    (haz2)
  );

  assign stall      = haz1 | haz2;
  assign in_ready_o = !stall && (!ex_valid_q || ex_ready_i);
  assign capture    = in_valid_i && in_ready_o;

  always_comb begin
    ex_valid_d = ex_valid_q;
    pc_d       = pc_q;
    aluop_d    = aluop_q;
    alusel_d   = alusel_q;
    reg1_d     = reg1_q;
    reg2_d     = reg2_q;
    wd_d       = wd_q;
    wreg_d     = wreg_q;
    ill_d      = ill_q;
    cnt_d      = cnt_q;
    if (flush_i) begin
      ex_valid_d = 1'b0;
    end else if (capture) begin
      ex_valid_d = 1'b1;
      pc_d       = pc_i;
      aluop_d    = dec.aluop;
      alusel_d   = dec.alusel;
      reg1_d     = op1;
      reg2_d     = op2;
      wd_d       = wd;
      wreg_d     = dec.wreg;
      ill_d      = dec.illegal;
    end else if (ex_ready_i) begin
      // Stalled with a free slot drains to a bubble.
      ex_valid_d = 1'b0;
    end
    if (in_valid_i && stall && !flush_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstActive) begin
      ex_valid_q <= 1'b0;
      pc_q       <= '0;
      aluop_q    <= AluNop;
      alusel_q   <= ResNop;
      reg1_q     <= '0;
      reg2_q     <= '0;
      wd_q       <= '0;
      wreg_q     <= 1'b0;
      ill_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      pc_q       <= pc_d;
      aluop_q    <= aluop_d;
      alusel_q   <= alusel_d;
      reg1_q     <= reg1_d;
      reg2_q     <= reg2_d;
      wd_q       <= wd_d;
      wreg_q     <= wreg_d;
      ill_q      <= ill_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ex_valid_o   = ex_valid_q;
  assign ex_pc_o      = pc_q;
  assign ex_aluop_o   = aluop_q;
  assign ex_alusel_o  = alusel_q;
  assign ex_reg1_o    = reg1_q;
  assign ex_reg2_o    = reg2_q;
  assign ex_wd_o      = wd_q;
  assign ex_wreg_o    = wreg_q;
  assign ex_illegal_o = ill_q;
  assign stall_cnt_o  = cnt_q;

endmodule

// File: tb/tb_id_issue_stage.sv
// Scoreboard bench for id_issue_stage; expectations follow ID_BYPASS_EN when it is defined.
module tb_id_issue_stage;

  localparam logic [7:0] OP_NOP = 8'h00, OP_AND = 8'h24, OP_OR = 8'h25;
  localparam logic [7:0] OP_XOR = 8'h26, OP_NOR = 8'h27;
  localparam logic [2:0] SEL_NOP = 3'd0, SEL_LOGIC = 3'd1;
`ifdef ID_BYPASS_EN
  localparam int FwdStall = 0;
`else
  localparam int FwdStall = 2;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  op;
    logic [2:0]  sel;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [4:0]  wd;
    logic        wreg;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0, rst = 1'b0;
  logic        in_valid_i = 1'b0, in_ready_o;
  logic [31:0] pc_i = '0, inst_i = '0;
  logic        reg1_read_o, reg2_read_o;
  logic [4:0]  reg1_addr_o, reg2_addr_o;
  logic [31:0] reg1_data_i, reg2_data_i;
  logic [1:0]  fwd_wreg_i = '0, fwd_pend_i = '0;
  logic [9:0]  fwd_wd_i = '0;
  logic [63:0] fwd_wdata_i = '0;
  logic        flush_i = 1'b0, ex_valid_o, ex_ready_i = 1'b1;
  logic [31:0] ex_pc_o, ex_reg1_o, ex_reg2_o;
  logic [7:0]  ex_aluop_o;
  logic [2:0]  ex_alusel_o;
  logic [4:0]  ex_wd_o;
  logic        ex_wreg_o, ex_illegal_o;
  logic [3:0]  stall_cnt_o;

  int   total = 0, bad = 0;
  exp_t sb[$];

  function automatic logic [31:0] rf(input logic [4:0] a);
    return {24'hF0F0F0, 3'b000, a};
  endfunction

  assign reg1_data_i = rf(reg1_addr_o);
  assign reg2_data_i = rf(reg2_addr_o);

  always #5 clk = ~clk;

  id_issue_stage #(.DATA_W(32), .REG_AW(5), .NUM_FWD(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .pc_i(pc_i), .inst_i(inst_i), .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o), .reg1_data_i(reg1_data_i),
    .reg2_data_i(reg2_data_i), .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i),
    .fwd_wdata_i(fwd_wdata_i), .fwd_pend_i(fwd_pend_i), .flush_i(flush_i),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i), .ex_pc_o(ex_pc_o),
    .ex_aluop_o(ex_aluop_o), .ex_alusel_o(ex_alusel_o), .ex_reg1_o(ex_reg1_o),
    .ex_reg2_o(ex_reg2_o), .ex_wd_o(ex_wd_o), .ex_wreg_o(ex_wreg_o),
    .ex_illegal_o(ex_illegal_o), .stall_cnt_o(stall_cnt_o)
  );

  // Pops one expectation per EX handshake.
  always @(negedge clk) begin
    if (rst && ex_valid_o && ex_ready_i) begin
      exp_t e, got;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_underflow: got op pc=%h, required no op", ex_pc_o);
      end else begin
        e   = sb.pop_front();
        got = '{pc: ex_pc_o, op: ex_aluop_o, sel: ex_alusel_o, r1: ex_reg1_o, r2: ex_reg2_o,
                wd: ex_wd_o, wreg: ex_wreg_o, ill: ex_illegal_o};
        if (got !== e) begin
          bad++;
          $display("FAIL id_ex pc=%h: got op=%h sel=%h r1=%h r2=%h wd=%0d wreg=%b ill=%b, required op=%h sel=%h r1=%h r2=%h wd=%0d wreg=%b ill=%b",
                   e.pc, got.op, got.sel, got.r1, got.r2, got.wd, got.wreg, got.ill,
                   e.op, e.sel, e.r1, e.r2, e.wd, e.wreg, e.ill);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish before 100us");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic exp_t mk(input logic [31:0] pc, input logic [7:0] op, input logic [2:0] sel,
                              input logic [31:0] r1, r2, input logic [4:0] wd,
                              input logic wreg, ill);
    return '{pc: pc, op: op, sel: sel, r1: r1, r2: r2, wd: wd, wreg: wreg, ill: ill};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic w, input logic [4:0] wd, input logic [31:0] d,
                        input logic p);
    fwd_wreg_i[k]          = w;
    fwd_wd_i[k*5 +: 5]     = wd;
    fwd_wdata_i[k*32 +: 32] = d;
    fwd_pend_i[k]          = p;
  endtask

  task automatic clr_ch();
    fwd_wreg_i = '0; fwd_wd_i = '0; fwd_wdata_i = '0; fwd_pend_i = '0;
  endtask

  // Presents one instruction until accepted; pushes its expectation on acceptance.
  task automatic send(input logic [31:0] pc, inst, input exp_t e, output int waited);
    in_valid_i = 1'b1; pc_i = pc; inst_i = inst; waited = 0;
    @(negedge clk);
    while (!in_ready_o && waited < 40) begin
      waited++;
      step();
      @(negedge clk);
    end
    total++;
    if (!in_ready_o) begin
      bad++;
      $display("FAIL accept_timeout pc=%h: got in_ready_o=0 after %0d cycles, required 1", pc,
               waited);
    end else begin
      sb.push_back(e);
    end
    step();
    in_valid_i = 1'b0;
  endtask

  task automatic chk_wait(input string name, input int got, input int req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %0d stall cycles, required %0d", name, got, req);
    end
  endtask

  task automatic test_reset();
    #3;
    total++;
    if ({ex_valid_o, stall_cnt_o, ex_pc_o, ex_aluop_o, ex_alusel_o} !== '0) begin
      bad++;
      $display("FAIL reset_ctrl: got valid=%b cnt=%0d pc=%h op=%h sel=%h, required all 0",
               ex_valid_o, stall_cnt_o, ex_pc_o, ex_aluop_o, ex_alusel_o);
    end
    total++;
    if ({ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o, ex_illegal_o} !== '0) begin
      bad++;
      $display("FAIL reset_data: got r1=%h r2=%h wd=%0d wreg=%b ill=%b, required all 0",
               ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o, ex_illegal_o);
    end
    step(); step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_decode();
    int w;
    repeat (2) step();
    // back-to-back, no hazards
    send(32'h100, itype(6'b001111, 5'd0, 5'd8, 16'hBEEF),
         mk(32'h100, OP_OR, SEL_LOGIC, 32'hBEEF0000, 32'hBEEF0000, 5'd8, 1'b1, 1'b0), w);
    send(32'h104, rtype(5'd1, 5'd2, 5'd9, 6'b100111),
         mk(32'h104, OP_NOR, SEL_LOGIC, rf(1), rf(2), 5'd9, 1'b1, 1'b0), w);
    send(32'h108, itype(6'b001110, 5'd2, 5'd10, 16'h8001),
         mk(32'h108, OP_XOR, SEL_LOGIC, rf(2), 32'h8001, 5'd10, 1'b1, 1'b0), w);
    send(32'h10C, 32'hFC00_0000, mk(32'h10C, OP_NOP, SEL_NOP, 0, 0, 5'd0, 1'b0, 1'b1), w);
    send(32'h110, 32'h0000_0008, mk(32'h110, OP_NOP, SEL_NOP, 0, 0, 5'd0, 1'b0, 1'b1), w);
    chk_wait("decode_no_stall", w, 0);
  endtask

  task automatic test_fwd();
    int w;
    repeat (2) step();
    set_ch(0, 1'b1, 5'd1, 32'h0F00, 1'b0);
    fork
      send(32'h200, itype(6'b001101, 5'd1, 5'd2, 16'h00F0),
`ifdef ID_BYPASS_EN
           mk(32'h200, OP_OR, SEL_LOGIC, 32'h0F00, 32'h00F0, 5'd2, 1'b1, 1'b0), w);
`else
           mk(32'h200, OP_OR, SEL_LOGIC, rf(1), 32'h00F0, 5'd2, 1'b1, 1'b0), w);
`endif
      begin repeat (2) step(); clr_ch(); end
    join
    chk_wait("fwd_ori", w, FwdStall);
  endtask

  task automatic test_priority();
    int w;
    repeat (2) step();
    set_ch(0, 1'b1, 5'd3, 32'hAAAA, 1'b0);
    set_ch(1, 1'b1, 5'd3, 32'h5555, 1'b1);  // older pending writer is shadowed by ch0
    fork
      send(32'h300, rtype(5'd3, 5'd3, 5'd4, 6'b100101),
`ifdef ID_BYPASS_EN
           mk(32'h300, OP_OR, SEL_LOGIC, 32'hAAAA, 32'hAAAA, 5'd4, 1'b1, 1'b0), w);
`else
           mk(32'h300, OP_OR, SEL_LOGIC, rf(3), rf(3), 5'd4, 1'b1, 1'b0), w);
`endif
      begin repeat (2) step(); clr_ch(); end
    join
    chk_wait("fwd_youngest", w, FwdStall);
  endtask

  task automatic test_load_use();
    int w;
    repeat (2) step();
    set_ch(0, 1'b1, 5'd5, 32'hDEAD, 1'b1);
    fork
      send(32'h400, itype(6'b001100, 5'd5, 5'd6, 16'h00FF),
           mk(32'h400, OP_AND, SEL_LOGIC, rf(5), 32'h00FF, 5'd6, 1'b1, 1'b0), w);
      begin
        step();
        @(negedge clk);
        total++;
        if (ex_valid_o !== 1'b0 || in_ready_o !== 1'b0) begin
          bad++;
          $display("FAIL load_use_bubble: got valid=%b ready=%b, required 0 0", ex_valid_o,
                   in_ready_o);
        end
        step(); step();
        clr_ch();
      end
    join
    chk_wait("load_use_stalls", w, 3);
    total++;
    if (stall_cnt_o !== 4'(2 * FwdStall + 3)) begin
      bad++;
      $display("FAIL load_use_cnt: got %0d, required %0d", stall_cnt_o, 2 * FwdStall + 3);
    end
  endtask

  task automatic test_zero();
    int w;
    repeat (2) step();
    set_ch(0, 1'b1, 5'd0, 32'h1234, 1'b0);
    set_ch(1, 1'b1, 5'd0, 32'h9999, 1'b1);
    send(32'h500, rtype(5'd0, 5'd0, 5'd7, 6'b100101),
         mk(32'h500, OP_OR, SEL_LOGIC, 32'h0, 32'h0, 5'd7, 1'b1, 1'b0), w);
    clr_ch();
    chk_wait("zero_no_stall", w, 0);
    total++;
    if (stall_cnt_o !== 4'(2 * FwdStall + 3)) begin
      bad++;
      $display("FAIL zero_cnt: got %0d, required %0d", stall_cnt_o, 2 * FwdStall + 3);
    end
  endtask

  task automatic test_backpressure();
    int w;
    repeat (2) step();
    ex_ready_i = 1'b0;
    send(32'h600, itype(6'b001101, 5'd1, 5'd11, 16'h0003),
         mk(32'h600, OP_OR, SEL_LOGIC, rf(1), 32'h0003, 5'd11, 1'b1, 1'b0), w);
    in_valid_i = 1'b1; pc_i = 32'h604; inst_i = itype(6'b001110, 5'd1, 5'd12, 16'h00F0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if ({in_ready_o, ex_valid_o, ex_pc_o, ex_reg1_o, ex_reg2_o, ex_wd_o} !==
          {1'b0, 1'b1, 32'h600, rf(1), 32'h0003, 5'd11}) begin
        bad++;
        $display("FAIL hold_%0d: got ready=%b valid=%b pc=%h r1=%h r2=%h wd=%0d, required 0 1 600 %h 3 11",
                 i, in_ready_o, ex_valid_o, ex_pc_o, ex_reg1_o, ex_reg2_o, ex_wd_o, rf(1));
      end
      step();
    end
    ex_ready_i = 1'b1;
    send(32'h604, itype(6'b001110, 5'd1, 5'd12, 16'h00F0),
         mk(32'h604, OP_XOR, SEL_LOGIC, rf(1), 32'h00F0, 5'd12, 1'b1, 1'b0), w);
  endtask

  task automatic test_flush();
    repeat (2) step();
    in_valid_i = 1'b1; pc_i = 32'h700; inst_i = itype(6'b001101, 5'd1, 5'd13, 16'h1);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0; in_valid_i = 1'b0;
    @(negedge clk);
    total++;
    if (ex_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL flush_capture: got ex_valid_o=%b, required 0", ex_valid_o);
    end
    ex_ready_i = 1'b0;
    step();
    in_valid_i = 1'b1;
    step();
    in_valid_i = 1'b0;
    @(negedge clk);
    total++;
    if (ex_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL flush_setup: got ex_valid_o=%b, required 1", ex_valid_o);
    end
    step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    @(negedge clk);
    total++;
    if (ex_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL flush_held: got ex_valid_o=%b, required 0", ex_valid_o);
    end
    ex_ready_i = 1'b1;
  endtask

  task automatic test_saturate();
    repeat (2) step();
    set_ch(0, 1'b1, 5'd5, 32'h0, 1'b1);
    in_valid_i = 1'b1; pc_i = 32'h800; inst_i = itype(6'b001100, 5'd5, 5'd6, 16'h1);
    repeat (20) step();
    in_valid_i = 1'b0;
    clr_ch();
    @(negedge clk);
    total++;
    if (stall_cnt_o !== 4'hF) begin
      bad++;
      $display("FAIL cnt_saturate: got %0d, required 15", stall_cnt_o);
    end
  endtask

  task automatic test_reset_mid();
    repeat (2) step();
    ex_ready_i = 1'b0;
    in_valid_i = 1'b1; pc_i = 32'h900; inst_i = itype(6'b001101, 5'd1, 5'd14, 16'h2);
    step();
    in_valid_i = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    total++;
    if ({ex_valid_o, stall_cnt_o, ex_reg1_o, ex_wd_o} !== '0) begin
      bad++;
      $display("FAIL reset_async: got valid=%b cnt=%0d r1=%h wd=%0d, required all 0",
               ex_valid_o, stall_cnt_o, ex_reg1_o, ex_wd_o);
    end
    step();
    rst = 1'b1;
    ex_ready_i = 1'b1;
    repeat (2) step();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d ops outstanding, required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_fwd();
    test_priority();
    test_load_use();
    test_zero();
    test_backpressure();
    test_flush();
    test_saturate();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
